axi_crossbar_mst_wr_router: RTL and testbench

//  Write-path router in the switch clock domain, directly downstream of the master-side CDC FIFOs.

---
 rtl/axi_crossbar_mst_wr_router.sv | 166 ++++++++++++++++
 tb/tb_axi_crossbar_mst_wr_router.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_crossbar_mst_wr_router.sv
// Master-side write router: decodes AW to a slave port, steers W beats in AW order
// and returns B in W-completion order; unmapped bursts are sunk and answered with DECERR.
module axi_crossbar_mst_wr_router #(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_ID_W        = 4,
  parameter int AWCH_W          = 53,
  parameter int WCH_W           = 47,
  parameter int BCH_W           = 12,
  parameter int NUM_SLV         = 4,
  parameter int SEL_W           = 2,
  parameter int MST_OSTDREQ_NUM = 4
) (
  input  logic                     i_aclk,
  input  logic                     i_aresetn,
  input  logic                     m_awvalid,
  output logic                     m_awready,
  input  logic [AWCH_W-1:0]        m_awch,
  input  logic                     m_wvalid,
  output logic                     m_wready,
  input  logic                     m_wlast,
  input  logic [WCH_W-1:0]         m_wch,
  output logic                     m_bvalid,
  input  logic                     m_bready,
  output logic [BCH_W-1:0]         m_bch,
  output logic [NUM_SLV-1:0]       s_awvalid,
  input  logic [NUM_SLV-1:0]       s_awready,
  output logic [AWCH_W-1:0]        s_awch,
  output logic [NUM_SLV-1:0]       s_wvalid,
  input  logic [NUM_SLV-1:0]       s_wready,
  output logic                     s_wlast,
  output logic [WCH_W-1:0]         s_wch,
  input  logic [NUM_SLV-1:0]       s_bvalid,
  output logic [NUM_SLV-1:0]       s_bready,
  input  logic [NUM_SLV*BCH_W-1:0] s_bch
);

  localparam int PTR_W = $clog2(MST_OSTDREQ_NUM);
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] OSTD_MAX = (PTR_W+1)'(MST_OSTDREQ_NUM);

  typedef struct packed {
    logic             decerr;
    logic [SEL_W-1:0] idx;
  } wq_entry_t;

  typedef struct packed {
    logic                decerr;
    logic [SEL_W-1:0]    idx;
    logic [AXI_ID_W-1:0] id;
  } bq_entry_t;

  wq_entry_t        wq_mem_q [MST_OSTDREQ_NUM];
  bq_entry_t        bq_mem_q [MST_OSTDREQ_NUM];
  logic [PTR_W:0]   wq_wptr_q, wq_wptr_d, wq_rptr_q, wq_rptr_d;
  logic [PTR_W:0]   bq_wptr_q, bq_wptr_d, bq_rptr_q, bq_rptr_d;
  logic [PTR_W:0]   ostd_cnt_q, ostd_cnt_d;

  logic             wq_full, wq_empty, bq_full, bq_empty;
  logic [SEL_W-1:0] aw_idx;
  logic             aw_decerr, can_aw, sel_awready, sel_wready, sel_bvalid;
  logic [BCH_W-1:0] sel_bch;
  logic             aw_hs, w_last_hs, b_hs;
  wq_entry_t        wq_head, wq_push;
  bq_entry_t        bq_head, bq_push;

  assign s_awch  = m_awch;
  assign s_wch   = m_wch;
  assign s_wlast = m_wlast;

  assign aw_idx    = m_awch[AXI_ADDR_W-1 -: SEL_W];
  assign aw_decerr = ({1'b0, aw_idx} >= (SEL_W+1)'(NUM_SLV));

  assign wq_empty = (wq_wptr_q == wq_rptr_q);
  assign wq_full  = (wq_wptr_q[PTR_W-1:0] == wq_rptr_q[PTR_W-1:0]) &&
                    (wq_wptr_q[PTR_W] != wq_rptr_q[PTR_W]);
  assign bq_empty = (bq_wptr_q == bq_rptr_q);
  assign bq_full  = (bq_wptr_q[PTR_W-1:0] == bq_rptr_q[PTR_W-1:0]) &&
                    (bq_wptr_q[PTR_W] != bq_rptr_q[PTR_W]);

  assign wq_head = wq_mem_q[wq_rptr_q[PTR_W-1:0]];
  assign bq_head = bq_mem_q[bq_rptr_q[PTR_W-1:0]];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    // Reset gates acceptance so no AW handshake can slip through while FIFOs are being cleared.
    can_aw      = i_aresetn & ~wq_full & (ostd_cnt_q < OSTD_MAX);
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bch     = '0;
    s_awvalid   = '0;
    s_wvalid    = '0;
    s_bready    = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (!aw_decerr && aw_idx == SEL_W'(k)) begin
        s_awvalid[k] = m_awvalid & can_aw;
        sel_awready  = s_awready[k];
      end
      if (!wq_empty && !wq_head.decerr && wq_head.idx == SEL_W'(k)) begin
        s_wvalid[k] = m_wvalid;
        sel_wready  = s_wready[k];
      end
      if (!bq_empty && !bq_head.decerr && bq_head.idx == SEL_W'(k)) begin
        s_bready[k] = m_bready;
        sel_bvalid  = s_bvalid[k];
        sel_bch     = s_bch[k*BCH_W +: BCH_W];
      end
    end
    m_awready = can_aw & (aw_decerr | sel_awready);
    m_wready  = ~wq_empty & (wq_head.decerr | sel_wready);
    m_bvalid  = ~bq_empty & (bq_head.decerr | sel_bvalid);
    if (bq_empty)            m_bch = '0;
    else if (bq_head.decerr) m_bch = BCH_W'({2'b11, bq_head.id});
    else                     m_bch = sel_bch;
  end

  always_comb begin
    aw_hs     = m_awvalid & m_awready;
    w_last_hs = m_wvalid & m_wready & m_wlast;
    b_hs      = m_bvalid & m_bready;

    wq_push.decerr = aw_decerr;
    wq_push.idx    = aw_idx;
    bq_push.decerr = wq_head.decerr;
    bq_push.idx    = wq_head.idx;
    bq_push.id     = m_wch[AXI_ID_W-1:0];

    wq_wptr_d  = aw_hs     ? wq_wptr_q + PTR_ONE : wq_wptr_q;
    wq_rptr_d  = w_last_hs ? wq_rptr_q + PTR_ONE : wq_rptr_q;
    bq_wptr_d  = w_last_hs ? bq_wptr_q + PTR_ONE : bq_wptr_q;
    bq_rptr_d  = b_hs      ? bq_rptr_q + PTR_ONE : bq_rptr_q;

    ostd_cnt_d = ostd_cnt_q;
    if (aw_hs && !b_hs)      ostd_cnt_d = ostd_cnt_q + PTR_ONE;
    else if (!aw_hs && b_hs) ostd_cnt_d = ostd_cnt_q - PTR_ONE;
  end

  // NOTE: storage arrays carry no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge i_aclk) begin
    if (aw_hs)     wq_mem_q[wq_wptr_q[PTR_W-1:0]] <= wq_push;
    if (w_last_hs) bq_mem_q[bq_wptr_q[PTR_W-1:0]] <= bq_push;
  end

  // NOTE: state flops use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      wq_wptr_q  <= '0;
      wq_rptr_q  <= '0;
      bq_wptr_q  <= '0;
      bq_rptr_q  <= '0;
      ostd_cnt_q <= '0;
    end else begin
      wq_wptr_q  <= wq_wptr_d;
      wq_rptr_q  <= wq_rptr_d;
      bq_wptr_q  <= bq_wptr_d;
      bq_rptr_q  <= bq_rptr_d;
      ostd_cnt_q <= ostd_cnt_d;
    end
  end

  // Entries in wq plus bq never exceed the outstanding cap, so bq cannot overflow.
  bq_no_overflow: assert property (@(posedge i_aclk) disable iff (!i_aresetn)
    !(w_last_hs && bq_full))
    else $error("bq push while full");

endmodule

// File: tb/tb_axi_crossbar_mst_wr_router.sv
// Directed bench for the write router: drives master and slave handshakes and checks
// routing, DECERR sinking, the outstanding cap, B ordering and async reset against scoreboards.
module tb_axi_crossbar_mst_wr_router;

  localparam int NS  = 3;
  localparam int BW  = 12;
  localparam int AWW = 53;
  localparam int WW  = 47;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m_awvalid, m_awready;
  logic [AWW-1:0]    m_awch;
  logic              m_wvalid, m_wready, m_wlast;
  logic [WW-1:0]     m_wch;
  logic              m_bvalid, m_bready;
  logic [BW-1:0]     m_bch;
  logic [NS-1:0]     s_awvalid, s_awready;
  logic [AWW-1:0]    s_awch;
  logic [NS-1:0]     s_wvalid, s_wready;
  logic              s_wlast;
  logic [WW-1:0]     s_wch;
  logic [NS-1:0]     s_bvalid, s_bready;
  logic [NS*BW-1:0]  s_bch;

  typedef struct {
    logic [NS-1:0] oh;
    logic [WW-1:0] wch;
    logic          last;
  } w_exp_t;

  typedef struct {
    int          slv;
    logic [BW-1:0] bch;
  } b_exp_t;

  w_exp_t exp_w_q[$];
  b_exp_t exp_b_q[$];
  int     errors = 0;
  int     checks = 0;
  int     waited;

  always #5 clk = ~clk;

  axi_crossbar_mst_wr_router #(
    .AXI_ADDR_W(32), .AXI_ID_W(4), .AWCH_W(AWW), .WCH_W(WW), .BCH_W(BW),
    .NUM_SLV(NS), .SEL_W(2), .MST_OSTDREQ_NUM(4)
  ) dut (
    .i_aclk(clk), .i_aresetn(rst_n),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awch(m_awch),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wch(m_wch),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bch(m_bch),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awch(s_awch),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wch(s_wch),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bch(s_bch)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: top two address bits select the slave; indices past NS are unmapped.
  function automatic int decode(input logic [31:0] addr);
    int idx;
    idx = int'(addr[31:30]);
    return (idx >= NS) ? -1 : idx;
  endfunction

  function automatic logic [NS-1:0] onehot(input int slv);
    logic [NS-1:0] v;
    v = '0;
    if (slv >= 0) v[slv] = 1'b1;
    return v;
  endfunction

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    bit done;
    done      = 1'b0;
    m_awch    = {9'd0, len, id, addr};
    m_awvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (m_awready) begin
        check("aw_route", s_awvalid, onehot(decode(addr)));
        check("aw_passthru", s_awch, m_awch);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("aw_handshake_seen", done, 1);
    m_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] id, input logic last, input logic [NS-1:0] oh);
    bit     done;
    w_exp_t e, f;
    logic [63:0] r;
    done   = 1'b0;
    r      = {$urandom, $urandom};
    e.oh   = oh;
    e.wch  = {r[42:0], id};
    e.last = last;
    exp_w_q.push_back(e);
    m_wch    = e.wch;
    m_wlast  = last;
    m_wvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (m_wready) begin
        f = exp_w_q.pop_front();
        check("w_route", s_wvalid, f.oh);
        check("w_data", s_wch, f.wch);
        check("w_last", s_wlast, f.last);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("w_handshake_seen", done, 1);
    m_wvalid = 1'b0;
    m_wlast  = 1'b0;
  endtask

  task automatic send_burst(input logic [31:0] addr, input int beats, input logic [3:0] id,
                            input logic [1:0] resp);
    b_exp_t e;
    int     slv;
    slv = decode(addr);
    for (int i = 0; i < beats; i++) send_w(id, i == beats - 1, onehot(slv));
    e.slv = slv;
    e.bch = (slv < 0) ? {6'd0, 2'b11, id} : {6'd0, resp, id};
    exp_b_q.push_back(e);
  endtask

  task automatic get_b(output int n_wait);
    bit     done;
    b_exp_t e;
    done   = 1'b0;
    n_wait = 0;
    check("b_scoreboard_nonempty", exp_b_q.size() > 0, 1);
    if (exp_b_q.size() == 0) return;
    e = exp_b_q.pop_front();
    if (e.slv >= 0) begin
      s_bvalid[e.slv]          = 1'b1;
      s_bch[e.slv*BW +: BW]    = e.bch;
    end
    m_bready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (m_bvalid) begin
        check("b_payload", m_bch, e.bch);
        check("b_slave_ready", s_bready, onehot(e.slv));
        done = 1'b1;
      end else begin
        n_wait++;
      end
      @(posedge clk); #1;
    end
    check("b_handshake_seen", done, 1);
    m_bready = 1'b0;
    if (e.slv >= 0) s_bvalid[e.slv] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every input pushing toward a handshake: all outputs must still be quiet.
    rst_n     = 1'b0;
    m_awvalid = 1'b1;
    m_awch    = {9'd0, 8'd0, 4'd1, 32'h4000_0000};
    m_wvalid  = 1'b1;
    m_wlast   = 1'b1;
    m_wch     = '0;
    m_bready  = 1'b1;
    s_awready = '1;
    s_wready  = '1;
    s_bvalid  = '1;
    s_bch     = {12'h3C3, 12'h5A5, 12'hA5A};
    #12;
    check("rst_m_awready", m_awready, 0);
    check("rst_m_wready", m_wready, 0);
    check("rst_m_bvalid", m_bvalid, 0);
    check("rst_s_awvalid", s_awvalid, 0);
    check("rst_s_wvalid", s_wvalid, 0);
    check("rst_s_bready", s_bready, 0);
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    s_bvalid  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single mapped burst to slave 1, OKAY response id 2.
    send_aw(32'h4000_0000, 8'd3, 4'd2);
    send_burst(32'h4000_0000, 4, 4'd2, 2'b00);
    get_b(waited);

    // Unmapped address: beats sunk, DECERR returned the cycle after the last beat.
    send_aw(32'hC000_0000, 8'd1, 4'd5);
    send_burst(32'hC000_0000, 2, 4'd5, 2'b00);
    get_b(waited);
    check("decerr_b_next_cycle", waited, 0);

    // Fill the outstanding cap with B withheld.
    send_aw(32'h0000_0000, 8'd0, 4'd1);
    send_burst(32'h0000_0000, 1, 4'd1, 2'b01);
    send_aw(32'h4000_0000, 8'd0, 4'd2);
    send_burst(32'h4000_0000, 1, 4'd2, 2'b01);
    send_aw(32'h8000_0000, 8'd0, 4'd3);
    send_burst(32'h8000_0000, 1, 4'd3, 2'b00);
    send_aw(32'h0000_1000, 8'd0, 4'd4);
    send_burst(32'h0000_1000, 1, 4'd4, 2'b01);
    m_awch    = {9'd0, 8'd0, 4'd6, 32'h4000_0000};
    m_awvalid = 1'b1;
    @(negedge clk);
    check("cap_m_awready", m_awready, 0);
    check("cap_s_awvalid", s_awvalid, 0);
    @(posedge clk); #1;
    get_b(waited);
    @(negedge clk);
    check("cap_release_awready", m_awready, 1);
    check("cap_release_awvalid", s_awvalid, 3'b010);
    @(posedge clk); #1;
    m_awvalid = 1'b0;
    get_b(waited);
    get_b(waited);
    send_burst(32'h4000_0000, 1, 4'd6, 2'b00);

    // Slave 1 answers early while slave 0 owns the bq head: it must be held off.
    s_bvalid[1]     = 1'b1;
    s_bch[BW +: BW] = 12'h0F6;
    m_bready        = 1'b1;
    @(negedge clk);
    check("order_s_bready", s_bready, 3'b001);
    check("order_m_bvalid", m_bvalid, 0);
    @(posedge clk); #1;
    get_b(waited);
    get_b(waited);

    // W arrives three cycles before its AW.
    m_wch    = {43'h0, 4'd7};
    m_wlast  = 1'b1;
    m_wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("early_w_m_wready", m_wready, 0);
      check("early_w_s_wvalid", s_wvalid, 0);
      @(posedge clk); #1;
    end
    send_aw(32'h8000_0000, 8'd0, 4'd7);
    send_burst(32'h8000_0000, 1, 4'd7, 2'b00);
    get_b(waited);

    // Reset asserted in the middle of a 4-beat burst.
    send_aw(32'h4000_0000, 8'd3, 4'd9);
    send_w(4'd9, 1'b0, 3'b010);
    send_w(4'd9, 1'b0, 3'b010);
    m_wch     = {43'h1234, 4'd9};
    m_wvalid  = 1'b1;
    m_awch    = {9'd0, 8'd0, 4'd3, 32'h0000_0000};
    m_awvalid = 1'b1;
    s_bvalid  = '1;
    m_bready  = 1'b1;
    #2;
    check("pre_rst_m_wready", m_wready, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_awready", m_awready, 0);
    check("mid_rst_m_wready", m_wready, 0);
    check("mid_rst_m_bvalid", m_bvalid, 0);
    check("mid_rst_s_awvalid", s_awvalid, 0);
    check("mid_rst_s_wvalid", s_wvalid, 0);
    check("mid_rst_s_bready", s_bready, 0);
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_bvalid  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_aw(32'h0000_0000, 8'd1, 4'd11);
    send_burst(32'h0000_0000, 2, 4'd11, 2'b00);
    get_b(waited);
    check("final_w_scoreboard_empty", exp_w_q.size(), 0);
    check("final_b_scoreboard_empty", exp_b_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
